alu_cond_flags: RTL



---
 rtl/alu_cond_flags.sv | 85 ++++++++
 1 files changed

// File: rtl/alu_cond_flags.sv
// alu_cond_flags: NZCV flag derivation, processor status flag register and
// ARM condition evaluation with condition-gated write enables and PC select.
module alu_cond_flags #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  input  logic [3:0]   cond,
  input  logic [1:0]   flag_w,
  input  logic         pcs,
  input  logic         reg_w,
  input  logic         mem_w,
  input  logic         no_write,
  output logic [3:0]   flags,
  output logic         cond_ex,
  output logic         pc_src,
  output logic         reg_write,
  output logic         mem_write
);

  // Stored flags split into the two independently written fields
  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;

  logic flag_n, flag_z, flag_c, flag_v;

  assign flag_n = nz_q[1];
  assign flag_z = nz_q[0];
  assign flag_c = cv_q[1];
  assign flag_v = cv_q[0];

  // Condition evaluation against the flags held before this instruction
  always_comb begin
    cond_ex = 1'b1;
    unique case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      default: cond_ex = 1'b1;
    endcase
  end

  // Next-state for each flag field; a failed condition holds both fields
  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (flag_w[1] && cond_ex) begin
      nz_d = {alu_result[N-1], (alu_result == '0)};
    end
    if (flag_w[0] && cond_ex) begin
      cv_d = {alu_carry, alu_overflow};
    end
  end

  // Flag register; reset takes priority over any flag write
  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  assign flags     = {nz_q, cv_q};
  assign pc_src    = pcs & cond_ex;
  assign reg_write = reg_w & cond_ex & ~no_write;
  assign mem_write = mem_w & cond_ex;

endmodule
